fixed_prio_arbiter: RTL and testbench

- Parameterised fixed-priority arbiter: picks one of NUM_REQ requesters each cycle. Bit 0 has the highest priority; priority falls as the index rises.
- Grant path is purely combinational and gated by a global allow_i.
- Clocked side logic provides:
  - a registered copy of the last grant and its encoded index;
  - an optional per-requester starvation monitor.
- Used as the leaf arbiter for shared-resource ports in the core.

---
 rtl/fixed_prio_arbiter.sv | 88 ++++++++
 tb/tb_fixed_prio_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_prio_arbiter.sv
// Fixed-priority arbiter (bit 0 highest) with registered grant copy.
// Optional starvation monitor enabled by defining FIXED_PRIO_ARB_STARVE_EN.
module fixed_prio_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int STARVE_THRESH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        allow_i,
    input  logic [NUM_REQ-1:0]          req_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        gnt_valid_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx_o,
    output logic [NUM_REQ-1:0]          gnt_q_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx_q_o,
    output logic [NUM_REQ-1:0]          starve_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;

    // Isolate the lowest set request bit: req & two's-complement(req).
    assign gnt = allow_i ? (req_i & (~req_i + NUM_REQ'(1))) : '0;

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = IDX_W'(i);
        end
    end

    assign gnt_o       = gnt;
    assign gnt_valid_o = |gnt;
    assign gnt_idx_o   = gnt_idx;

    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            gnt_q     <= gnt;
            gnt_idx_q <= gnt_idx;
        end
    end

    assign gnt_q_o     = gnt_q;
    assign gnt_idx_q_o = gnt_idx_q;

`ifdef FIXED_PRIO_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_THRESH + 1);

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] starve_q;
    logic [NUM_REQ-1:0] starve_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = '0;
            if (req_i[i] && !gnt[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_W'(STARVE_THRESH)) ? cnt_q[i]
                                                               : cnt_q[i] + CNT_W'(1);
            end
            starve_d[i] = (cnt_d[i] == CNT_W'(STARVE_THRESH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
            starve_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            starve_q <= starve_d;
        end
    end

    assign starve_o = starve_q;
`else
    assign starve_o = '0;
`endif

endmodule

// File: tb/tb_fixed_prio_arbiter.sv
// Directed and randomised self-checking bench for fixed_prio_arbiter (NUM_REQ=4, STARVE_THRESH=4).
module tb_fixed_prio_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       allow_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       gnt_valid_o;
    logic [1:0] gnt_idx_o;
    logic [3:0] gnt_q_o;
    logic [1:0] gnt_idx_q_o;
    logic [3:0] starve_o;

    int errors = 0;
    int checks = 0;

`ifdef FIXED_PRIO_ARB_STARVE_EN
    localparam bit STARVE_BUILD = 1'b1;
`else
    localparam bit STARVE_BUILD = 1'b0;
`endif

    fixed_prio_arbiter #(.NUM_REQ(4), .STARVE_THRESH(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .allow_i     (allow_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_q_o     (gnt_q_o),
        .gnt_idx_q_o (gnt_idx_q_o),
        .starve_o    (starve_o)
    );

    always #5 clk_i = ~clk_i;

    // Independent model: scan upward for the first requesting bit.
    function automatic logic [3:0] exp_gnt(input logic a, input logic [3:0] r);
        logic [3:0] g;
        g = 4'b0000;
        if (a) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    g[i] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [1:0] exp_idx(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; allow_i = 1'b1; req_i = 4'b0110;
        step();
        checks++;
        if (gnt_q_o !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt_q got=%b exp=0000", gnt_q_o);
        end
        checks++;
        if (gnt_idx_q_o !== 2'd0) begin
            errors++; $display("FAIL reset_idx_q got=%0d exp=0", gnt_idx_q_o);
        end
        checks++;
        if (starve_o !== 4'b0000) begin
            errors++; $display("FAIL reset_starve got=%b exp=0000", starve_o);
        end
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++; $display("FAIL reset_gnt_comb got=%b exp=0010", gnt_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        allow_i = 1'b1; req_i = 4'b1010;
        #2;
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++; $display("FAIL basic_gnt got=%b exp=0010", gnt_o);
        end
        checks++;
        if (gnt_idx_o !== 2'd1) begin
            errors++; $display("FAIL basic_idx got=%0d exp=1", gnt_idx_o);
        end
        checks++;
        if (gnt_valid_o !== 1'b1) begin
            errors++; $display("FAIL basic_valid got=%b exp=1", gnt_valid_o);
        end
        step();
        checks++;
        if (gnt_q_o !== 4'b0010) begin
            errors++; $display("FAIL basic_gnt_q got=%b exp=0010", gnt_q_o);
        end
        checks++;
        if (gnt_idx_q_o !== 2'd1) begin
            errors++; $display("FAIL basic_idx_q got=%0d exp=1", gnt_idx_q_o);
        end
    endtask

    task automatic test_boundary();
        logic       a_tab [5];
        logic [3:0] r_tab [5];
        logic [3:0] g_tab [5];
        logic [1:0] i_tab [5];
        a_tab[0] = 1'b0; r_tab[0] = 4'b1111; g_tab[0] = 4'b0000; i_tab[0] = 2'd0;
        a_tab[1] = 1'b1; r_tab[1] = 4'b0000; g_tab[1] = 4'b0000; i_tab[1] = 2'd0;
        a_tab[2] = 1'b1; r_tab[2] = 4'b1111; g_tab[2] = 4'b0001; i_tab[2] = 2'd0;
        a_tab[3] = 1'b0; r_tab[3] = 4'b0000; g_tab[3] = 4'b0000; i_tab[3] = 2'd0;
        a_tab[4] = 1'b1; r_tab[4] = 4'b1000; g_tab[4] = 4'b1000; i_tab[4] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            allow_i = a_tab[k]; req_i = r_tab[k];
            #2;
            checks++;
            if (gnt_o !== g_tab[k] || gnt_idx_o !== i_tab[k] || gnt_valid_o !== (|g_tab[k])) begin
                errors++;
                $display("FAIL boundary_%0d got gnt=%b idx=%0d valid=%b exp gnt=%b idx=%0d valid=%b",
                         k, gnt_o, gnt_idx_o, gnt_valid_o, g_tab[k], i_tab[k], |g_tab[k]);
            end
            step();
            checks++;
            if (gnt_q_o !== g_tab[k] || gnt_idx_q_o !== i_tab[k]) begin
                errors++;
                $display("FAIL boundary_q_%0d got gnt_q=%b idx_q=%0d exp gnt_q=%b idx_q=%0d",
                         k, gnt_q_o, gnt_idx_q_o, g_tab[k], i_tab[k]);
            end
        end
    endtask

    task automatic test_starve();
        logic [3:0] exp_s;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        allow_i = 1'b1; req_i = 4'b0011;
        for (int e = 1; e <= 6; e++) begin
            step();
            exp_s = (STARVE_BUILD && e >= 4) ? 4'b0010 : 4'b0000;
            checks++;
            if (starve_o !== exp_s) begin
                errors++; $display("FAIL starve_edge_%0d got=%b exp=%b", e, starve_o, exp_s);
            end
        end
        req_i = 4'b0010;
        #2;
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++; $display("FAIL starve_drop_gnt got=%b exp=0010", gnt_o);
        end
        exp_s = STARVE_BUILD ? 4'b0010 : 4'b0000;
        checks++;
        if (starve_o !== exp_s) begin
            errors++; $display("FAIL starve_hold got=%b exp=%b", starve_o, exp_s);
        end
        step();
        checks++;
        if (starve_o !== 4'b0000) begin
            errors++; $display("FAIL starve_clear got=%b exp=0000", starve_o);
        end
        // allow_i=0 cycles count as unserved for a held request
        rst_i = 1'b1; step(); rst_i = 1'b0;
        allow_i = 1'b0; req_i = 4'b0001;
        for (int e = 1; e <= 4; e++) step();
        exp_s = STARVE_BUILD ? 4'b0001 : 4'b0000;
        checks++;
        if (starve_o !== exp_s) begin
            errors++; $display("FAIL starve_disallow got=%b exp=%b", starve_o, exp_s);
        end
        allow_i = 1'b1;
        step();
        checks++;
        if (starve_o !== 4'b0000) begin
            errors++; $display("FAIL starve_granted_clear got=%b exp=0000", starve_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg, prev_g;
        logic [1:0] prev_i;
        logic       in_rst;
        prev_g = gnt_o; prev_i = gnt_idx_o;
        for (int c = 0; c < 3000; c++) begin
            in_rst  = (c == 1500 || c == 1501);
            rst_i   = in_rst;
            allow_i = 1'($urandom_range(0, 1));
            req_i   = 4'($urandom);
            #2;
            eg = exp_gnt(allow_i, req_i);
            checks++;
            if (gnt_o !== eg || gnt_idx_o !== exp_idx(eg) || gnt_valid_o !== (|eg)) begin
                errors++;
                $display("FAIL random_comb c=%0d a=%b r=%b got gnt=%b idx=%0d valid=%b exp gnt=%b idx=%0d",
                         c, allow_i, req_i, gnt_o, gnt_idx_o, gnt_valid_o, eg, exp_idx(eg));
            end
            prev_g = in_rst ? 4'b0000 : eg;
            prev_i = in_rst ? 2'd0 : exp_idx(eg);
            step();
            checks++;
            if (gnt_q_o !== prev_g || gnt_idx_q_o !== prev_i) begin
                errors++;
                $display("FAIL random_reg c=%0d got gnt_q=%b idx_q=%0d exp gnt_q=%b idx_q=%0d",
                         c, gnt_q_o, gnt_idx_q_o, prev_g, prev_i);
            end
            if (in_rst) begin
                checks++;
                if (starve_o !== 4'b0000) begin
                    errors++; $display("FAIL random_rst_starve c=%0d got=%b exp=0000", c, starve_o);
                end
            end
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; allow_i = 1'b0; req_i = 4'b0000;
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
